fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the pipelined RV32 core. It sits directly upstream of the decode stage and control unit.
- Owns the PC register and next-PC selection (sequential, branch/jump, trap, mret).
- Drives the combinational instruction-memory address.
- Owns the IF/ID pipeline register, including stall, flush/bubble insertion and halt-on-EBREAK.
- Replaces the free-running PC+4 address generator and the standalone IF/ID register.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TRAP_VEC, 32'h0000_0100, PC loaded when trap_req is taken
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in instructionD on flush/reset
EBREAK_INSTR, 32'h0010_0073, encoding that halts fetch when it reaches decode

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
StallF  in  1  hold PC (from hazard unit)
StallD  in  1  hold IF/ID register
FlushD  in  1  replace IF/ID contents with bubble
PCSrcE  in  1  taken branch/jump resolved in EX
PCTargetE  in  32  branch/jump target from EX
trap_req  in  1  interrupt/exception redirect request (one-cycle pulse)
mret  in  1  return-from-trap request (one-cycle pulse)
epc  in  32  return address for mret
imem_addr  out  32  instruction-memory address (= pc)
imem_rdata  in  32  instruction word, combinational read of imem_addr
pc  out  32  current fetch PC
pcD  out  32  PC of the instruction in decode
instructionD  out  32  instruction in decode
PCPlus4D  out  32  pcD + 4
validD  out  1  instructionD is a real instruction (0 = bubble)
halted  out  1  fetch stopped on EBREAK
misalign  out  1  one-cycle pulse: the selected redirect target had bits[1:0] != 0
instr_count  out  32  number of instructions accepted into decode

Behaviour:
Reset (async, rst=1):
- pc=RESET_PC
- pcD=0, instructionD=NOP_INSTR, PCPlus4D=0, validD=0
- halted=0, misalign=0, instr_count=0
- FSM=RUN
- Reset mid-operation discards all state immediately, with no dependence on clk.

FSM states:
- RUN -> HALTED when validD=1, instructionD==EBREAK_INSTR and StallD=0.
- HALTED -> RUN only when trap_req=1 (debug/interrupt resume) or on reset.
- In HALTED: pc holds, IF/ID loads bubbles (validD=0), halted=1.

Next-PC selection, evaluated each rising edge in RUN, highest priority first:
1. trap_req: pc <= TRAP_VEC
2. mret: pc <= {epc[31:2],2'b00}
3. PCSrcE: pc <= {PCTargetE[31:2],2'b00}
4. StallF: pc holds
5. otherwise: pc <= pc+4, wrapping modulo 2^32

Redirect rules:
- Redirects (1-3) override StallF.
- misalign pulses for one cycle when the selected redirect target (case 2 or 3) has bits[1:0]!=0.

IF/ID register, each rising edge:
- FlushD, or any redirect (1-3): bubble (instructionD=NOP_INSTR, validD=0, pcD/PCPlus4D=0). Flush has priority over StallD.
- else StallD: hold all fields.
- else load pcD<=pc, instructionD<=imem_rdata, PCPlus4D<=pc+4, validD<=1.

instr_count:
- Increments by 1 on each edge where IF/ID loads a real instruction.
- Wraps 32'hFFFF_FFFF -> 0.

Latency and timing:
- Fetch-to-decode latency is 1 cycle.
- Branch penalty is 2 cycles: instructions in IF and ID are squashed.
- imem_addr is purely combinational from pc, so there is no extra latency.

Simultaneous events:
- trap_req with PCSrcE: trap wins.
- mret with StallF: mret wins.
- trap_req while HALTED: resumes at TRAP_VEC.

Decomposition:
- Shared package core_pkg holds RESET_PC, TRAP_VEC, NOP_INSTR, EBREAK_INSTR and the fetch FSM state enum (RUN, HALTED).
- One sub-module, next_pc_sel: the combinational priority mux that produces next PC plus the misalign flag.
- PC register, IF/ID register, FSM and counter stay in fetch_stage.

Test Plan:
1. Sequential fetch: reset, release, imem returns pc-based words, no stalls, 4 cycles.
   -> pc = 0, 4, 8, C, 10; pcD lags pc by one cycle; instr_count=3 after the third load; validD=1 from cycle 2.
2. Stall: StallF=StallD=1 for 2 cycles at pc=8.
   -> pc stays 8; pcD/instructionD held; instr_count unchanged; resumes at C.
3. Taken branch: PCSrcE=1, PCTargetE=32'h40, FlushD=1 at pc=10.
   -> next pc=40; IF/ID bubble (instructionD=32'h13, validD=0); next decode pcD=40.
4. Trap and mret priority: trap_req=1 with PCSrcE=1 (PCTargetE=32'h80).
   -> pc=32'h100. Later mret=1 with epc=32'h22 and StallF=1 -> pc=32'h20, misalign pulses 1 cycle.
5. Halt: imem returns 32'h00100073 at pc=C.
   -> one cycle after it reaches decode, halted=1 and pc frozen; trap_req then gives pc=32'h100 and halted=0.
6. Async reset mid-run: assert rst between clock edges at pc=24.
   -> pc=0, validD=0, instr_count=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core constants and the fetch-stage FSM state type.
package core_pkg;

   localparam logic [31:0] RESET_PC     = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC     = 32'h0000_0100;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
   localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_e;

   // Clear the two low bits of a redirect target.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_next_pc_sel.sv
// Next-PC priority mux: trap > mret > branch/jump > stall > sequential.
module next_pc_sel
   import core_pkg::*;
#(
   parameter logic [31:0] TRAP_VEC = core_pkg::TRAP_VEC
) (
   input  logic [31:0] pc,
   input  logic        run,
   input  logic        StallF,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   input  logic        trap_req,
   input  logic        mret,
   input  logic [31:0] epc,
   output logic [31:0] next_pc,
   output logic [31:0] pc_plus4,
   output logic        redirect,
   output logic        misalign
);

   // Select the next fetch PC and flag redirects and misaligned targets.
   always_comb begin
      pc_plus4 = pc + 32'd4;
      next_pc  = pc;
      redirect = 1'b0;
      misalign = 1'b0;
      if (trap_req) begin
         next_pc  = TRAP_VEC;
         redirect = 1'b1;
      end else if (!run) begin
         // Halted: only a trap may move the PC.
         next_pc = pc;
      end else if (mret) begin
         next_pc  = word_align(epc);
         redirect = 1'b1;
         misalign = |epc[1:0];
      end else if (PCSrcE) begin
         next_pc  = word_align(PCTargetE);
         redirect = 1'b1;
         misalign = |PCTargetE[1:0];
      end else if (StallF) begin
         next_pc = pc;
      end else begin
         next_pc = pc_plus4;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID register, halt FSM and
// accepted-instruction counter.
module fetch_stage
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = core_pkg::RESET_PC,
   parameter logic [31:0] TRAP_VEC     = core_pkg::TRAP_VEC,
   parameter logic [31:0] NOP_INSTR    = core_pkg::NOP_INSTR,
   parameter logic [31:0] EBREAK_INSTR = core_pkg::EBREAK_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   input  logic        trap_req,
   input  logic        mret,
   input  logic [31:0] epc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] pcD,
   output logic [31:0] instructionD,
   output logic [31:0] PCPlus4D,
   output logic        validD,
   output logic        halted,
   output logic        misalign,
   output logic [31:0] instr_count
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  pcd_q, pcd_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  pcplus4_q, pcplus4_d;
   logic         valid_q, valid_d;
   logic         halted_q, halted_d;
   logic         misalign_q, misalign_d;
   logic [31:0]  count_q, count_d;

   logic [31:0]  sel_next_pc;
   logic [31:0]  sel_pc_plus4;
   logic         sel_redirect;
   logic         sel_misalign;
   logic         load_real;

   next_pc_sel #(
      .TRAP_VEC (TRAP_VEC)
   ) u_next_pc_sel (
      .pc        (pc_q),
      .run       (state_q == RUN),
      .StallF    (StallF),
      .PCSrcE    (PCSrcE),
      .PCTargetE (PCTargetE),
      .trap_req  (trap_req),
      .mret      (mret),
      .epc       (epc),
      .next_pc   (sel_next_pc),
      .pc_plus4  (sel_pc_plus4),
      .redirect  (sel_redirect),
      .misalign  (sel_misalign)
   );

   // Next-state logic for the FSM, PC, IF/ID register and counter.
   always_comb begin
      state_d    = state_q;
      pc_d       = sel_next_pc;
      misalign_d = sel_misalign;
      pcd_d      = pcd_q;
      instr_d    = instr_q;
      pcplus4_d  = pcplus4_q;
      valid_d    = valid_q;
      load_real  = 1'b0;

      // An EBREAK squashed by a flush or redirect must not halt fetch.
      if (state_q == HALTED) begin
         if (trap_req) state_d = RUN;
      end else if (!sel_redirect && !FlushD && !StallD &&
                   valid_q && (instr_q == EBREAK_INSTR)) begin
         state_d = HALTED;
      end
      halted_d = (state_d == HALTED);

      if (FlushD || sel_redirect || (state_q == HALTED)) begin
         pcd_d     = '0;
         instr_d   = NOP_INSTR;
         pcplus4_d = '0;
         valid_d   = 1'b0;
      end else if (!StallD) begin
         pcd_d     = pc_q;
         instr_d   = imem_rdata;
         pcplus4_d = sel_pc_plus4;
         valid_d   = 1'b1;
         load_real = 1'b1;
      end

      count_d = load_real ? count_q + 32'd1 : count_q;
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         pcd_q      <= '0;
         instr_q    <= NOP_INSTR;
         pcplus4_q  <= '0;
         valid_q    <= 1'b0;
         halted_q   <= 1'b0;
         misalign_q <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pcd_q      <= pcd_d;
         instr_q    <= instr_d;
         pcplus4_q  <= pcplus4_d;
         valid_q    <= valid_d;
         halted_q   <= halted_d;
         misalign_q <= misalign_d;
         count_q    <= count_d;
      end
   end

   assign imem_addr    = pc_q;
   assign pc           = pc_q;
   assign pcD          = pcd_q;
   assign instructionD = instr_q;
   assign PCPlus4D     = pcplus4_q;
   assign validD       = valid_q;
   assign halted       = halted_q;
   assign misalign     = misalign_q;
   assign instr_count  = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an expected-state scoreboard.
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        StallF, StallD, FlushD, PCSrcE, trap_req, mret;
   logic [31:0] PCTargetE, epc;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] pc, pcD, instructionD, PCPlus4D, instr_count;
   logic        validD, halted, misalign;
   logic        ebreak_en;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pcd;
      logic [31:0] instr;
      logic [31:0] plus4;
      logic        valid;
      logic        halted;
      logic        mis;
      logic [31:0] cnt;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    n_assert = 0;
   int    n_fail   = 0;

   fetch_stage #(
      .RESET_PC     (32'h0000_0000),
      .TRAP_VEC     (32'h0000_0100),
      .NOP_INSTR    (32'h0000_0013),
      .EBREAK_INSTR (32'h0010_0073)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .StallF       (StallF),
      .StallD       (StallD),
      .FlushD       (FlushD),
      .PCSrcE       (PCSrcE),
      .PCTargetE    (PCTargetE),
      .trap_req     (trap_req),
      .mret         (mret),
      .epc          (epc),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .pc           (pc),
      .pcD          (pcD),
      .instructionD (instructionD),
      .PCPlus4D     (PCPlus4D),
      .validD       (validD),
      .halted       (halted),
      .misalign     (misalign),
      .instr_count  (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: address-tagged words, optional EBREAK at 0xC.
   always_comb begin
      if (ebreak_en && (imem_addr == 32'h0000_000C)) imem_rdata = 32'h0010_0073;
      else imem_rdata = 32'hA000_0000 | imem_addr;
   end

   function automatic logic [31:0] w(input logic [31:0] a);
      return 32'hA000_0000 | a;
   endfunction

   function automatic exp_t mk(input logic [31:0] p, input logic [31:0] pd,
                               input logic [31:0] ins, input logic v,
                               input logic h, input logic m, input logic [31:0] c);
      exp_t e;
      e.pc     = p;
      e.pcd    = pd;
      e.instr  = ins;
      e.plus4  = v ? pd + 32'd4 : 32'd0;
      e.valid  = v;
      e.halted = h;
      e.mis    = m;
      e.cnt    = c;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", name, obs, expv);
      end
   endtask

   task automatic compare_front();
      exp_t  e;
      string t;
      if (exp_q.size() == 0) begin
         n_assert++;
         n_fail++;
         $display("FAIL scoreboard_empty: observed no entry expected one");
         return;
      end
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk({t, ".pc"},           pc,                 e.pc);
      chk({t, ".imem_addr"},    imem_addr,          e.pc);
      chk({t, ".pcD"},          pcD,                e.pcd);
      chk({t, ".instructionD"}, instructionD,       e.instr);
      chk({t, ".PCPlus4D"},     PCPlus4D,           e.plus4);
      chk({t, ".validD"},       {31'd0, validD},    {31'd0, e.valid});
      chk({t, ".halted"},       {31'd0, halted},    {31'd0, e.halted});
      chk({t, ".misalign"},     {31'd0, misalign},  {31'd0, e.mis});
      chk({t, ".instr_count"},  instr_count,        e.cnt);
   endtask

   task automatic check_now(input string tag, input exp_t e);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      compare_front();
   endtask

   task automatic step(input string tag, input exp_t e);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      compare_front();
   endtask

   task automatic drive(input logic sf, input logic sd, input logic fd, input logic br,
                        input logic [31:0] tgt, input logic tr, input logic mr,
                        input logic [31:0] ep);
      StallF    = sf;
      StallD    = sd;
      FlushD    = fd;
      PCSrcE    = br;
      PCTargetE = tgt;
      trap_req  = tr;
      mret      = mr;
      epc       = ep;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      ebreak_en = 1'b0;
      idle();
      #2;
      check_now("reset", mk(32'h0, 32'h0, 32'h13, 1'b0, 1'b0, 1'b0, 32'd0));
      #1 rst = 1'b0;

      // Sequential fetch
      step("seq1", mk(32'h4,  32'h0, w(32'h0), 1'b1, 1'b0, 1'b0, 32'd1));
      step("seq2", mk(32'h8,  32'h4, w(32'h4), 1'b1, 1'b0, 1'b0, 32'd2));
      step("seq3", mk(32'hC,  32'h8, w(32'h8), 1'b1, 1'b0, 1'b0, 32'd3));
      step("seq4", mk(32'h10, 32'hC, w(32'hC), 1'b1, 1'b0, 1'b0, 32'd4));

      // Stall at pc=8
      pulse_reset();
      step("s_run1", mk(32'h4, 32'h0, w(32'h0), 1'b1, 1'b0, 1'b0, 32'd1));
      step("s_run2", mk(32'h8, 32'h4, w(32'h4), 1'b1, 1'b0, 1'b0, 32'd2));
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      step("stall1", mk(32'h8, 32'h4, w(32'h4), 1'b1, 1'b0, 1'b0, 32'd2));
      step("stall2", mk(32'h8, 32'h4, w(32'h4), 1'b1, 1'b0, 1'b0, 32'd2));
      idle();
      step("resume", mk(32'hC, 32'h8, w(32'h8), 1'b1, 1'b0, 1'b0, 32'd3));

      // Taken branch at pc=0x10
      step("pre_br", mk(32'h10, 32'hC, w(32'hC), 1'b1, 1'b0, 1'b0, 32'd4));
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'd0);
      step("branch", mk(32'h40, 32'h0, 32'h13, 1'b0, 1'b0, 1'b0, 32'd4));
      idle();
      step("br_tgt", mk(32'h44, 32'h40, w(32'h40), 1'b1, 1'b0, 1'b0, 32'd5));

      // Trap beats branch; mret beats StallF with misaligned epc
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 1'b0, 32'd0);
      step("trap", mk(32'h100, 32'h0, 32'h13, 1'b0, 1'b0, 1'b0, 32'd5));
      idle();
      step("trap_vec", mk(32'h104, 32'h100, w(32'h100), 1'b1, 1'b0, 1'b0, 32'd6));
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h22);
      step("mret", mk(32'h20, 32'h0, 32'h13, 1'b0, 1'b0, 1'b1, 32'd6));
      idle();
      step("mret_next", mk(32'h24, 32'h20, w(32'h20), 1'b1, 1'b0, 1'b0, 32'd7));

      // Asynchronous reset between edges at pc=0x24
      #3;
      rst = 1'b1;
      #1;
      check_now("async_rst", mk(32'h0, 32'h0, 32'h13, 1'b0, 1'b0, 1'b0, 32'd0));
      #2 rst = 1'b0;
      step("post_rst", mk(32'h4, 32'h0, w(32'h0), 1'b1, 1'b0, 1'b0, 32'd1));

      // FlushD beats StallD; misaligned branch target; branch beats StallF
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      step("flush_stall", mk(32'h8, 32'h0, 32'h13, 1'b0, 1'b0, 1'b0, 32'd1));
      idle();
      step("after_flush", mk(32'hC, 32'h8, w(32'h8), 1'b1, 1'b0, 1'b0, 32'd2));
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h43, 1'b0, 1'b0, 32'd0);
      step("br_misal", mk(32'h40, 32'h0, 32'h13, 1'b0, 1'b0, 1'b1, 32'd2));
      idle();
      step("br_misal_n", mk(32'h44, 32'h40, w(32'h40), 1'b1, 1'b0, 1'b0, 32'd3));
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h60, 1'b0, 1'b0, 32'd0);
      step("br_stallf", mk(32'h60, 32'h0, 32'h13, 1'b0, 1'b0, 1'b0, 32'd3));
      idle();

      // Halt on EBREAK at 0xC, resume via trap
      pulse_reset();
      ebreak_en = 1'b1;
      step("h1", mk(32'h4,  32'h0, w(32'h0), 1'b1, 1'b0, 1'b0, 32'd1));
      step("h2", mk(32'h8,  32'h4, w(32'h4), 1'b1, 1'b0, 1'b0, 32'd2));
      step("h3", mk(32'hC,  32'h8, w(32'h8), 1'b1, 1'b0, 1'b0, 32'd3));
      step("h_ebrk", mk(32'h10, 32'hC, 32'h0010_0073, 1'b1, 1'b0, 1'b0, 32'd4));
      step("h_halt", mk(32'h14, 32'h10, w(32'h10), 1'b1, 1'b1, 1'b0, 32'd5));
      step("h_frz1", mk(32'h14, 32'h0, 32'h13, 1'b0, 1'b1, 1'b0, 32'd5));
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'd0);
      step("h_frz2", mk(32'h14, 32'h0, 32'h13, 1'b0, 1'b1, 1'b0, 32'd5));
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      step("h_trap", mk(32'h100, 32'h0, 32'h13, 1'b0, 1'b0, 1'b0, 32'd5));
      idle();
      step("h_run", mk(32'h104, 32'h100, w(32'h100), 1'b1, 1'b0, 1'b0, 32'd6));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
